// File: rtl/flp_norm.sv
// Post-add normaliser/rounder: iterative one-bit normalise, RNE round, IEEE pack.
// Define FLP_NORM_FTZ_EN to flush denormal results to signed zero.
module flp_norm #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic                            i_sn,
  input  logic [FRAC_WIDTH+3:0]           i_sg,
  input  logic                            i_zero,
  input  logic [EXP_WIDTH-1:0]            i_exp,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]   o_result,
  output logic                            o_ovf,
  output logic                            o_zero
);

  localparam int SW = FRAC_WIDTH + 4;
  localparam int XW = EXP_WIDTH + 1;
  localparam int RW = EXP_WIDTH + FRAC_WIDTH;

  typedef enum logic [1:0] {
    IDLE, NORM, ROUND, DONE
  } state_t;

  state_t state, state_nx;

  logic                  sn;
  logic [SW-1:0]         sg;
  logic [XW-1:0]         exp;
  logic [RW:0]           res;
  logic                  ovf;
  logic                  zero;

  logic                  carry, hidden, exp_one;
  logic                  inc, pre_ovf, post_ovf;
  logic [RW:0]           sum;
  logic [FRAC_WIDTH-1:0] frac;
  logic [EXP_WIDTH-1:0]  nexp;

  assign carry   = sg[SW-1];
  assign hidden  = sg[SW-2];
  assign exp_one = (exp == XW'(1));

  assign inc  = sg[1] & (sg[0] | sg[2]);
  assign sum  = {1'b0, exp[EXP_WIDTH-1:0], sg[FRAC_WIDTH+1:2]}
              + (RW+1)'(inc);
  assign frac = sum[FRAC_WIDTH-1:0];
  assign nexp = sum[RW-1:FRAC_WIDTH];

  // exp may already sit at/above all-ones after a carry shift in NORM
  assign pre_ovf  = (exp >= XW'((1 << EXP_WIDTH) - 1));
  assign post_ovf = sum[RW] | (&nexp);

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_valid) state_nx = i_zero ? DONE : NORM;
      end
      NORM: begin
        if (carry || hidden || exp_one) state_nx = ROUND;
      end
      ROUND: state_nx = DONE;
      DONE: begin
        if (i_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sn   <= 1'b0;
      sg   <= '0;
      exp  <= '0;
      res  <= '0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            sn  <= i_sn;
            sg  <= i_sg;
            exp <= (i_exp == '0) ? XW'(1) : {1'b0, i_exp};
            if (i_zero) begin
              sn   <= 1'b0;
              res  <= '0;
              ovf  <= 1'b0;
              zero <= 1'b1;
            end
          end
        end
        NORM: begin
          if (carry) begin
            sg  <= {1'b0, sg[SW-1:2], sg[1] | sg[0]};
            exp <= exp + XW'(1);
          end else if (hidden) begin
            sg <= sg;
          end else if (exp_one) begin
            exp <= '0;
          end else begin
            sg  <= {sg[SW-2:0], 1'b0};
            exp <= exp - XW'(1);
          end
        end
        ROUND: begin
          if (pre_ovf || post_ovf) begin
            res  <= {sn, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            ovf  <= 1'b1;
            zero <= 1'b0;
          end else begin
            ovf <= 1'b0;
`ifdef FLP_NORM_FTZ_EN
            if (nexp == '0) begin
              res  <= {sn, {RW{1'b0}}};
              zero <= 1'b1;
            end else begin
              res  <= {sn, nexp, frac};
              zero <= 1'b0;
            end
`else
            res  <= {sn, nexp, frac};
            zero <= (nexp == '0) && (frac == '0);
`endif
          end
        end
        DONE: begin
          sg <= sg;
        end
        default: begin
          sg <= sg;
        end
      endcase
    end
  end

  assign o_result = res;
  assign o_ovf    = ovf;
  assign o_zero   = zero;

endmodule

// File: tb/tb_flp_norm.sv
// Directed bench for flp_norm: values, latency, rounding, overflow,
// denormals, DONE back-pressure and mid-normalisation reset.
module tb_flp_norm;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sn;
  logic [26:0] i_sg;
  logic        i_zero;
  logic [7:0]  i_exp;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_ovf;
  logic        o_zero;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flp_norm dut (
    .clk      (clk),
    .nrst     (nrst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sn     (i_sn),
    .i_sg     (i_sg),
    .i_zero   (i_zero),
    .i_exp    (i_exp),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_ovf    (o_ovf),
    .o_zero   (o_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp_v);
    n_assert++;
    assert (got === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp_v);
    end
  endtask

  task automatic run(input string tag, input logic sn,
                     input logic [26:0] sg, input logic [7:0] e,
                     input logic z, input logic [31:0] er,
                     input logic eo, input logic ez, input int el,
                     input int hold);
    int lat;
    logic [31:0] first;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_sn    = sn;
    i_sg    = sg;
    i_exp   = e;
    i_zero  = z;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(el));
    chk({tag, "_res"}, o_result, er);
    chk({tag, "_ovf"}, 32'(o_ovf), 32'(eo));
    chk({tag, "_zero"}, 32'(o_zero), 32'(ez));
    first = o_result;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_res"}, o_result, first);
      chk({tag, "_hold_rdy"}, 32'(o_ready), 32'd0);
      chk({tag, "_hold_vld"}, 32'(o_valid), 32'd1);
    end
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    chk({tag, "_drop_vld"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    nrst    = 1'b0;
    i_valid = 1'b0;
    i_sn    = 1'b0;
    i_sg    = '0;
    i_zero  = 1'b0;
    i_exp   = '0;
    i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_res", o_result, 32'h0);
    chk("rst_flags", {30'd0, o_ovf, o_zero}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    run("one",   1'b0, 27'h2000000, 8'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3, 0);
    run("carry", 1'b0, 27'h4000000, 8'd127, 1'b0, 32'h40000000, 1'b0, 1'b0, 3, 0);
    run("lsh23", 1'b0, 27'h0000004, 8'd127, 1'b0, 32'h34000000, 1'b0, 1'b0, 26, 0);
    run("lsh25", 1'b0, 27'h0000001, 8'd127, 1'b0, 32'h33000000, 1'b0, 1'b0, 28, 0);
    run("tie0",  1'b0, 27'h2000002, 8'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3, 0);
    run("tie1",  1'b0, 27'h2000006, 8'd127, 1'b0, 32'h3F800002, 1'b0, 1'b0, 3, 0);
    run("ovf",   1'b0, 27'h3FFFFFE, 8'd254, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3, 0);
    run("covf",  1'b1, 27'h4000000, 8'd254, 1'b0, 32'hFF800000, 1'b1, 1'b0, 3, 0);
    run("exp0",  1'b0, 27'h2000000, 8'd0,   1'b0, 32'h00800000, 1'b0, 1'b0, 3, 0);
`ifdef FLP_NORM_FTZ_EN
    run("denorm", 1'b1, 27'h1000000, 8'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, 3, 0);
`else
    run("denorm", 1'b1, 27'h1000000, 8'd1, 1'b0, 32'h80400000, 1'b0, 1'b0, 3, 0);
`endif
    run("dnup",  1'b0, 27'h1FFFFFE, 8'd1,   1'b0, 32'h00800000, 1'b0, 1'b0, 3, 0);
    run("zero",  1'b1, 27'h0000000, 8'd90,  1'b1, 32'h00000000, 1'b0, 1'b1, 1, 0);
    run("hold",  1'b1, 27'h2000006, 8'd130, 1'b0, 32'hC1000002, 1'b0, 1'b0, 3, 5);

    // leave a nonzero result registered, then reset mid-normalisation
    @(negedge clk);
    i_valid = 1'b1;
    i_sn    = 1'b0;
    i_sg    = 27'h0000004;
    i_exp   = 8'd127;
    i_zero  = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(o_ready), 32'd0);
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_ready", 32'(o_ready), 32'd1);
    chk("mr_valid", 32'(o_valid), 32'd0);
    chk("mr_res", o_result, 32'h0);
    chk("mr_flags", {30'd0, o_ovf, o_zero}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_stay_idle", 32'(o_valid), 32'd0);

    run("after", 1'b0, 27'h2000000, 8'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/flp_norm.md
Name: flp_norm

Overview:
- Post-addition normaliser/rounder for the single-precision FP adder.
- Consumes the signed-magnitude sum from the integer adder stage (sign, WIDTH+1-bit magnitude, zero flag) plus the aligned exponent.
- Normalises iteratively, one bit per cycle, then rounds to nearest-even and packs an IEEE-754 word.
- Valid/ready handshake on both sides; multi-cycle, one operation in flight.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- FRAC_WIDTH, 23, fraction field width. Input magnitude width is FRAC_WIDTH+4.

Ports:
- clk  input  1  clock
- nrst  input  1  synchronous active-low reset
- i_valid  input  1  upstream operand valid
- o_ready  output  1  block can accept an operand
- i_sn  input  1  sign of the sum
- i_sg  input  FRAC_WIDTH+4  magnitude. Bit FRAC_WIDTH+3 = carry, FRAC_WIDTH+2 = hidden one, FRAC_WIDTH+1..2 = fraction, 1 = guard, 0 = sticky
- i_zero  input  1  sum is exactly zero
- i_exp  input  EXP_WIDTH  biased exponent of the aligned operands; 0 is treated as 1
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_result  output  EXP_WIDTH+FRAC_WIDTH+1  packed IEEE result
- o_ovf  output  1  result is infinity due to overflow
- o_zero  output  1  result magnitude is zero

Behaviour:
- One clock (clk). Reset is synchronous, active-low (nrst).
- Reset, or nrst low in any state including mid-normalisation, forces:
  - state IDLE, o_ready=1, o_valid=0
  - o_result=0, o_ovf=0, o_zero=0
  - internal sg/exp cleared
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE: o_ready=1. On i_valid, capture i_sn, i_sg, i_exp (0 mapped to 1).
  - If i_zero=1: go to DONE with result +0 (sign forced 0), o_zero=1.
  - Otherwise go to NORM.
- NORM (evaluate in this priority order):
  - Carry bit set: shift right 1, new bit0 = old bit1 | old bit0 (sticky), exp+1, go to ROUND.
  - Else hidden bit set: go to ROUND.
  - Else exp==1: exp=0 (denormal), no shift, go to ROUND.
  - Else: shift left 1 (bit0 filled 0), exp-1, stay in NORM.
- ROUND:
  - inc = guard & (sticky | lsb), where lsb = sg bit 2.
  - {exp, frac} = {exp, sg[FRAC_WIDTH+1:2]} + inc, computed as one EXP_WIDTH+FRAC_WIDTH-bit add.
  - Mantissa carry therefore increments exp, and a denormal rounding up becomes the smallest normal.
  - If the resulting exp is all-ones, or exp reached all-ones in NORM: result = signed infinity (frac=0), o_ovf=1.
  - o_zero=1 if exp and frac are both 0.
  - Go to DONE.
- DONE: o_valid=1; o_result/o_ovf/o_zero stable. On i_ready, go to IDLE and drop o_valid the next cycle.
- o_ready is 1 only in IDLE. There is no accept while DONE, even if i_ready is high in the same cycle.
- Latency, counted from the accept edge to the first cycle with o_valid=1:
  - zero input: 1 cycle
  - already normalised or carry input: 3 cycles
  - each left shift: +1 cycle
  - worst case (FRAC_WIDTH+2 shifts): 28 cycles
- Exponent arithmetic uses EXP_WIDTH+1 bits internally; exp never decrements below 0 (the exp==1 rule stops it).

Optional Feature:
- Macro: FLP_NORM_FTZ_EN.
- Defined: after ROUND, a result with exp field 0 and nonzero frac is flushed to signed zero ({sn, 0...}) with o_zero=1. Results that round up into the normal range are not flushed.
- Undefined: gradual underflow; denormals are output as computed.

Test Plan:
- sn=0, sg=0x2000000, exp=127 -> 0x3F800000; o_valid exactly 3 cycles after accept; o_ovf=0.
- sn=0, sg=0x4000000, exp=127 (carry) -> 0x40000000.
- sn=0, sg=0x0000004, exp=127 -> 23 left shifts, exp=104 -> 0x34000000, o_valid 26 cycles after accept.
- Rounding:
  - sg=0x2000002 (tie, lsb 0) -> 0x3F800000.
  - sg=0x2000006 (tie, lsb 1) -> 0x3F800002.
  - sg=0x3FFFFFE, exp=254 -> 0x7F800000 with o_ovf=1.
- Denormal:
  - sn=1, sg=0x1000000, exp=1 -> 0x80400000; with FLP_NORM_FTZ_EN -> 0x80000000, o_zero=1.
  - i_zero=1 -> 0x00000000 one cycle after accept.
- Control:
  - Hold i_ready=0 for 5 cycles in DONE -> o_result stable, o_ready=0 throughout.
  - Assert nrst=0 during NORM -> next cycle IDLE, o_valid=0, o_ready=1, outputs zero.
